mips_data_mem_responder: RTL and testbench

//   Responder (memory side) for the CPU's Harvard data port. It serves word

---
 rtl/mips_data_mem_responder_if.sv | 37 +++
 rtl/mips_data_mem_responder.sv | 134 +++++++++++++
 tb/tb_mips_data_mem_responder.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mips_data_mem_responder_if.sv
// Data-port bus between the CPU (master) and its data memory responder (slave).
//   data_address    CPU -> mem  byte address
//   data_read       CPU -> mem  read request, level, held while stalled
//   data_write      CPU -> mem  write request, level, held while stalled
//   data_writedata  CPU -> mem  write data
//   data_readdata   mem -> CPU  read data, valid in the completion cycle only
//   clk_enable      mem -> CPU  CPU clock enable; low freezes the CPU
//   err             mem -> CPU  sticky access-error flag
interface mips_data_mem_responder_if;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic        clk_enable;
    logic        err;

    modport master (
        output data_address,
        output data_read,
        output data_write,
        output data_writedata,
        input  data_readdata,
        input  clk_enable,
        input  err
    );

    modport slave (
        input  data_address,
        input  data_read,
        input  data_write,
        input  data_writedata,
        output data_readdata,
        output clk_enable,
        output err
    );
endinterface

// File: rtl/mips_data_mem_responder.sv
// Memory-side responder for the CPU's Harvard data port. Serves word reads and
// writes from an internal RAM, stalling the CPU through clk_enable for
// WAIT_CYCLES cycles and then releasing it for one completion (DONE) cycle.
// Ports:
//   clk    rising-edge system clock
//   reset  asynchronous, active-low reset
//   bus    data-port bus (slave side), see mips_data_mem_responder_if
// Parameters:
//   ADDR_W       word-address bits; RAM depth = 2**ADDR_W words
//   BASE_ADDR    byte address of RAM word 0
//   WAIT_CYCLES  stall cycles per access, 1..15
module mips_data_mem_responder #(
    parameter int unsigned ADDR_W      = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic                        clk,
    input logic                        reset,
    mips_data_mem_responder_if.slave   bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // One past the last valid byte address; 33 bits so the window cannot wrap.
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'd1 << (ADDR_W + 2));

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] ram [2**ADDR_W];

    logic              req;
    logic              both;
    logic              enter_done;
    logic              addr_valid;
    logic [31:0]       offset;
    logic [ADDR_W-1:0] word_idx;

    assign req  = bus.data_read ^ bus.data_write;
    assign both = bus.data_read & bus.data_write;

    always_comb begin
        offset     = bus.data_address - BASE_ADDR;
        word_idx   = ADDR_W'(offset >> 2);
        addr_valid = (bus.data_address[1:0] == 2'b00) &&
                     ({1'b0, bus.data_address} >= {1'b0, BASE_ADDR}) &&
                     ({1'b0, bus.data_address} < END_ADDR);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES <= 1) begin
                        state_d    = DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                // A request dropped mid-stall abandons the access.
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    state_d    = DONE;
                    cnt_d      = 4'd0;
                    enter_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (enter_done) begin
            rdata_d = (addr_valid && bus.data_read) ? ram[word_idx] : 32'h0;
        end
        err_d = err_q | both | (enter_done & ~addr_valid);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Commit on the DONE->IDLE edge, the same edge the CPU commits the store.
    // state_q is held at IDLE during reset, so an interrupted write never lands.
    always_ff @(posedge clk) begin
        if (state_q == DONE && bus.data_write && !bus.data_read && addr_valid) begin
            ram[word_idx] <= bus.data_writedata;
        end
    end

    always_comb begin
        if (!reset) begin
            bus.clk_enable = 1'b1;
        end else begin
            bus.clk_enable = !(((state_q == IDLE) && req) || (state_q == WAIT));
        end
    end

    assign bus.data_readdata = (state_q == DONE) ? rdata_q : 32'h0;
    assign bus.err           = err_q;

endmodule

// File: tb/tb_mips_data_mem_responder.sv
module tb_mips_data_mem_responder;

    logic clk;
    logic reset;

    int n_chk;
    int n_err;

    mips_data_mem_responder_if bus1();
    mips_data_mem_responder_if bus2();

    mips_data_mem_responder #(
        .ADDR_W      (10),
        .BASE_ADDR   (32'h0000_1000),
        .WAIT_CYCLES (1)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    mips_data_mem_responder #(
        .ADDR_W      (10),
        .BASE_ADDR   (32'h0000_1000),
        .WAIT_CYCLES (2)
    ) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // WAIT_CYCLES=2 access: two stalled cycles then one DONE cycle.
    task automatic op2(input string tag, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic chk_rd, input logic [31:0] exp_rd);
        bus2.data_address   = addr;
        bus2.data_writedata = wd;
        bus2.data_read      = rd;
        bus2.data_write     = wr;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk({tag, " stall ce"}, {31'd0, bus2.clk_enable}, 32'd0);
            chk({tag, " stall rdata"}, bus2.data_readdata, 32'd0);
        end
        @(negedge clk);
        chk({tag, " done ce"}, {31'd0, bus2.clk_enable}, 32'd1);
        if (chk_rd) chk({tag, " done rdata"}, bus2.data_readdata, exp_rd);
        @(posedge clk);
        #1;
        bus2.data_read  = 1'b0;
        bus2.data_write = 1'b0;
    endtask

    // WAIT_CYCLES=1 access: one stalled cycle then one DONE cycle.
    task automatic op1(input string tag, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic chk_rd, input logic [31:0] exp_rd);
        bus1.data_address   = addr;
        bus1.data_writedata = wd;
        bus1.data_read      = rd;
        bus1.data_write     = wr;
        @(negedge clk);
        chk({tag, " stall ce"}, {31'd0, bus1.clk_enable}, 32'd0);
        @(negedge clk);
        chk({tag, " done ce"}, {31'd0, bus1.clk_enable}, 32'd1);
        if (chk_rd) chk({tag, " done rdata"}, bus1.data_readdata, exp_rd);
        @(posedge clk);
        #1;
        bus1.data_read  = 1'b0;
        bus1.data_write = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b0;
        bus1.data_address = 32'h0; bus1.data_writedata = 32'h0;
        bus1.data_read = 1'b0;     bus1.data_write = 1'b0;
        bus2.data_address = 32'h1004; bus2.data_writedata = 32'h0;
        bus2.data_read = 1'b1;        bus2.data_write = 1'b0;

        // Reset held with a read pending: CPU must not be frozen.
        repeat (2) @(negedge clk);
        chk("reset ce", {31'd0, bus2.clk_enable}, 32'd1);
        chk("reset rdata", bus2.data_readdata, 32'd0);
        chk("reset err", {31'd0, bus2.err}, 32'd0);
        @(posedge clk);
        #1;
        bus2.data_read = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("idle ce", {31'd0, bus2.clk_enable}, 32'd1);

        // WAIT_CYCLES=2: write then read back.
        @(posedge clk);
        #1;
        op2("w2 deadbeef", 1'b0, 1'b1, 32'h1004, 32'hDEAD_BEEF, 1'b0, 32'h0);
        op2("r2 1004", 1'b1, 1'b0, 32'h1004, 32'h0, 1'b1, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("idle rdata", bus2.data_readdata, 32'd0);
        chk("dut2 err clear", {31'd0, bus2.err}, 32'd0);

        // WAIT_CYCLES=1: preload, then back-to-back reads with read held high.
        @(posedge clk);
        #1;
        op1("w1 1000", 1'b0, 1'b1, 32'h1000, 32'h0000_0011, 1'b0, 32'h0);
        op1("w1 1008", 1'b0, 1'b1, 32'h1008, 32'h0000_0022, 1'b0, 32'h0);
        op1("w1 1ffc", 1'b0, 1'b1, 32'h1FFC, 32'h0000_5A5A, 1'b0, 32'h0);
        bus1.data_address = 32'h1000;
        bus1.data_read    = 1'b1;
        @(negedge clk);
        chk("b2b ce0", {31'd0, bus1.clk_enable}, 32'd0);
        @(negedge clk);
        chk("b2b ce1", {31'd0, bus1.clk_enable}, 32'd1);
        chk("b2b data0", bus1.data_readdata, 32'h11);
        @(posedge clk);
        #1;
        bus1.data_address = 32'h1008;
        @(negedge clk);
        chk("b2b ce2", {31'd0, bus1.clk_enable}, 32'd0);
        @(negedge clk);
        chk("b2b ce3", {31'd0, bus1.clk_enable}, 32'd1);
        chk("b2b data1", bus1.data_readdata, 32'h22);
        @(posedge clk);
        #1;
        bus1.data_read = 1'b0;
        op1("r1 top word", 1'b1, 1'b0, 32'h1FFC, 32'h0, 1'b1, 32'h0000_5A5A);
        chk("dut1 err clear", {31'd0, bus1.err}, 32'd0);

        // Read and write together: no stall, err set, RAM untouched.
        bus1.data_address   = 32'h1000;
        bus1.data_writedata = 32'hFFFF_FFFF;
        bus1.data_read      = 1'b1;
        bus1.data_write     = 1'b1;
        @(negedge clk);
        chk("both ce0", {31'd0, bus1.clk_enable}, 32'd1);
        @(negedge clk);
        chk("both ce1", {31'd0, bus1.clk_enable}, 32'd1);
        chk("both err", {31'd0, bus1.err}, 32'd1);
        @(posedge clk);
        #1;
        bus1.data_read  = 1'b0;
        bus1.data_write = 1'b0;
        op1("both ram", 1'b1, 1'b0, 32'h1000, 32'h0, 1'b1, 32'h11);
        op1("r1 above top", 1'b1, 1'b0, 32'h2000, 32'h0, 1'b1, 32'h0);
        chk("both err sticky", {31'd0, bus1.err}, 32'd1);

        // Invalid addresses on the WAIT_CYCLES=2 responder.
        op2("r2 misaligned", 1'b1, 1'b0, 32'h1002, 32'h0, 1'b1, 32'h0);
        chk("misaligned err", {31'd0, bus2.err}, 32'd1);
        op2("r2 below base", 1'b1, 1'b0, 32'h0FFC, 32'h0, 1'b1, 32'h0);
        @(negedge clk);
        chk("err sticky", {31'd0, bus2.err}, 32'd1);

        // Reset during the stall of a write: write is lost, CPU released at once.
        @(posedge clk);
        #1;
        op2("w2 old", 1'b0, 1'b1, 32'h1010, 32'h1234_5678, 1'b0, 32'h0);
        bus2.data_address   = 32'h1010;
        bus2.data_writedata = 32'hCAFE_F00D;
        bus2.data_write     = 1'b1;
        @(negedge clk);
        chk("rst-mid ce stall", {31'd0, bus2.clk_enable}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst-mid in wait ce", {31'd0, bus2.clk_enable}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rst-mid ce", {31'd0, bus2.clk_enable}, 32'd1);
        chk("rst-mid err", {31'd0, bus2.err}, 32'd0);
        @(posedge clk);
        #1;
        bus2.data_write = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        op2("r2 after rst", 1'b1, 1'b0, 32'h1010, 32'h0, 1'b1, 32'h1234_5678);
        op2("r2 keep 1004", 1'b1, 1'b0, 32'h1004, 32'h0, 1'b1, 32'hDEAD_BEEF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
